color_cmd_arbiter: RTL and testbench

- Round-robin arbiter that shares the 2-bit command input of one Color state machine among NUM_REQ requesters.
- Each requester presents a command; the arbiter selects one, drives it downstream with a valid/ready handshake, and acks the winner.
- Enforces a programmable cooldown between consecutive grants so the downstream FSM settles before the next command.
- Sits between the requester agents and the Color FSM's command input.

---
 rtl/color_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/color_cmd_arbiter.sv | 124 ++++++++++++
 tb/tb_color_cmd_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/color_arb_pkg.sv
// rtl/color_arb_pkg.sv - shared state encoding and command constants for the color command arbiter
package color_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'h0,
        ARB_ISSUE    = 2'h1,
        ARB_COOLDOWN = 2'h2
    } arb_state_t;

    // Command codes also decoded by the Color FSM input stage
    localparam logic [1:0] CMD_HOLD   = 2'h0;
    localparam logic [1:0] CMD_TOGGLE = 2'h1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               found,
    output logic [PW-1:0]      idx
);

    localparam logic [PW:0] N = (PW+1)'(NUM_REQ);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest hit to ptr wins
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (PW+1)'(k);
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_cand = w_sum[PW-1:0];
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/color_cmd_arbiter.sv
// rtl/color_cmd_arbiter.sv - round-robin command arbiter with cooldown; COLOR_ARB_STATS_EN adds grant/stall counters
module color_cmd_arbiter
    import color_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CMD_WIDTH   = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   cmd_in,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           out_valid,
    output logic [CMD_WIDTH-1:0]           out_cmd,
    input  logic                           out_ready,
    output logic                           busy
`ifdef COLOR_ARB_STATS_EN
    ,
    output logic [15:0]                    grant_count,
    output logic [15:0]                    stall_count
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [PW-1:0] LAST      = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);

    arb_state_t           r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_winner;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [CW-1:0]        r_cnt;

    logic                 w_found;
    logic [PW-1:0]        w_idx;
    logic [CMD_WIDTH-1:0] w_sel_cmd;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == PW'(i)) begin
                w_sel_cmd = cmd_in[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_cmd    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_idx;
                        r_cmd    <= w_sel_cmd;
                        r_state  <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (out_ready) begin
                        r_ptr <= (r_winner == LAST) ? '0 : r_winner + PW'(1);
                        if (HOLD_CYCLES == 0) begin
                            r_state <= ARB_IDLE;
                        end else begin
                            r_state <= ARB_COOLDOWN;
                            r_cnt   <= HOLD_INIT;
                        end
                    end
                end
                ARB_COOLDOWN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ARB_ISSUE);
    assign busy      = (r_state != ARB_IDLE);
    assign out_cmd   = r_cmd;
    assign ack       = (r_state == ARB_ISSUE && out_ready) ? (NUM_REQ'(1) << r_winner) : '0;

`ifdef COLOR_ARB_STATS_EN
    logic [15:0] r_grant_count;
    logic [15:0] r_stall_count;

    // Grants wrap freely; stalls saturate so a wedged sink stays visible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_count <= '0;
            r_stall_count <= '0;
        end else if (r_state == ARB_ISSUE) begin
            if (out_ready) begin
                r_grant_count <= r_grant_count + 16'd1;
            end else if (r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign grant_count = r_grant_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_color_cmd_arbiter.sv
// tb/tb_color_cmd_arbiter.sv - directed vector bench for color_cmd_arbiter (stats checks when COLOR_ARB_STATS_EN)
module tb_color_cmd_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] cmd_in;
    logic [3:0] ack;
    logic       out_valid;
    logic [1:0] out_cmd;
    logic       out_ready;
    logic       busy;
`ifdef COLOR_ARB_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] stall_count;
`endif

    int n_vec;
    int n_fail;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [7:0] cmd;
        logic       rdy;
        logic [3:0] e_ack;
        logic       e_valid;
        logic [1:0] e_cmd;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    color_cmd_arbiter #(
        .NUM_REQ     (4),
        .CMD_WIDTH   (2),
        .HOLD_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cmd_in    (cmd_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_cmd   (out_cmd),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef COLOR_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic [7:0] c, input logic rdy,
                       input logic [3:0] ea, input logic ev, input logic [1:0] ec, input logic eb);
        vec_t v;
        v.rst_n = r; v.req = q; v.cmd = c; v.rdy = rdy;
        v.e_ack = ea; v.e_valid = ev; v.e_cmd = ec; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string name, input logic [3:0] ea, input logic ev,
                              input logic [1:0] ec, input logic eb);
        n_vec++;
        if (ack !== ea || out_valid !== ev || out_cmd !== ec || busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got ack=%b valid=%b cmd=%h busy=%b, want ack=%b valid=%b cmd=%h busy=%b",
                     name, ack, out_valid, out_cmd, busy, ea, ev, ec, eb);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check outputs before the rising edge
    task automatic cyc(input logic r, input logic [3:0] q, input logic [7:0] c, input logic rdy,
                       input logic [3:0] ea, input logic ev, input logic [1:0] ec, input logic eb,
                       input string name);
        @(negedge clk);
        rst = r; req = q; cmd_in = c; out_ready = rdy;
        #1;
        check_outs(name, ea, ev, ec, eb);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        rst = 1'b0; req = 4'h0; cmd_in = 8'h00; out_ready = 1'b0;

        // Reset held with all requests up, then fairness sweep; requester i carries cmd i
        for (int i = 0; i < 3; i++) add(0, 4'hF, 8'hE4, 1, 4'h0, 0, 2'h0, 0);
        add(1, 4'hF, 8'hE4, 1, 4'h0, 0, 2'h0, 0);
        for (int g = 0; g < 5; g++) begin
            add(1, 4'hF, 8'hE4, 1, 4'(1 << (g % 4)), 1, 2'(g % 4), 1);
            if (g < 4) begin
                add(1, 4'hF, 8'hE4, 1, 4'h0, 0, 2'(g % 4), 1);
                add(1, 4'hF, 8'hE4, 1, 4'h0, 0, 2'(g % 4), 1);
                add(1, 4'hF, 8'hE4, 1, 4'h0, 0, 2'(g % 4), 0);
            end
        end

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst_n, vecs[i].req, vecs[i].cmd, vecs[i].rdy,
                vecs[i].e_ack, vecs[i].e_valid, vecs[i].e_cmd, vecs[i].e_busy,
                $sformatf("fair_vec%0d", i));
        end

        // Backpressure: requester 2 stalls five cycles, then is accepted
        cyc(0, 4'b0000, 8'h00, 0, 4'h0, 0, 2'h0, 0, "bp_rst");
        cyc(1, 4'b0100, 8'h10, 0, 4'h0, 0, 2'h0, 0, "bp_idle");
        for (int i = 0; i < 5; i++) cyc(1, 4'b0100, 8'h10, 0, 4'h0, 1, 2'h1, 1, "bp_stall");
        cyc(1, 4'b0100, 8'h10, 1, 4'b0100, 1, 2'h1, 1, "bp_accept");
        cyc(1, 4'b0000, 8'h10, 1, 4'h0, 0, 2'h1, 1, "bp_cool");

        // Latching: cmd_in and req change after latch without affecting the in-flight command
        cyc(0, 4'b0000, 8'h00, 0, 4'h0, 0, 2'h0, 0, "lt_rst");
        cyc(1, 4'b0010, 8'h04, 0, 4'h0, 0, 2'h0, 0, "lt_idle");
        cyc(1, 4'b0010, 8'h00, 0, 4'h0, 1, 2'h1, 1, "lt_hold1");
        cyc(1, 4'b0010, 8'h00, 0, 4'h0, 1, 2'h1, 1, "lt_hold2");
        cyc(1, 4'b0000, 8'h00, 1, 4'b0010, 1, 2'h1, 1, "lt_accept");

        // Reset mid-Issue: advance ptr to 1, latch requester 1, then reset asynchronously
        cyc(0, 4'b0000, 8'h00, 0, 4'h0, 0, 2'h0, 0, "rm_rst");
        cyc(1, 4'b0001, 8'h00, 1, 4'h0, 0, 2'h0, 0, "rm_idle");
        cyc(1, 4'b0001, 8'h00, 1, 4'b0001, 1, 2'h0, 1, "rm_g0");
        cyc(1, 4'b0000, 8'h00, 1, 4'h0, 0, 2'h0, 1, "rm_cd1");
        cyc(1, 4'b0000, 8'h00, 1, 4'h0, 0, 2'h0, 1, "rm_cd2");
        cyc(1, 4'b0010, 8'h0C, 0, 4'h0, 0, 2'h0, 0, "rm_idle2");
        cyc(1, 4'b0010, 8'h0C, 0, 4'h0, 1, 2'h3, 1, "rm_issue");
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_outs("rm_async", 4'h0, 0, 2'h0, 0);
        cyc(1, 4'b0011, 8'h0D, 1, 4'h0, 0, 2'h0, 0, "rm_release");
        cyc(1, 4'b0011, 8'h0D, 1, 4'b0001, 1, 2'h1, 1, "rm_ptr0");

`ifdef COLOR_ARB_STATS_EN
        cyc(0, 4'b0000, 8'h00, 0, 4'h0, 0, 2'h0, 0, "st_rst");
        cyc(1, 4'b0001, 8'h01, 0, 4'h0, 0, 2'h0, 0, "st_idle");
        for (int i = 0; i < 4; i++) cyc(1, 4'b0001, 8'h01, 0, 4'h0, 1, 2'h1, 1, "st_stall");
        for (int g = 0; g < 3; g++) begin
            if (g > 0) begin
                cyc(1, 4'b0001, 8'h01, 0, 4'h0, 0, 2'h1, 0, "st_idle_n");
            end
            cyc(1, 4'b0001, 8'h01, 1, 4'b0001, 1, 2'h1, 1, "st_accept");
            cyc(1, 4'b0001, 8'h01, 1, 4'h0, 0, 2'h1, 1, "st_cd1");
            cyc(1, 4'b0001, 8'h01, 1, 4'h0, 0, 2'h1, 1, "st_cd2");
        end
        n_vec++;
        if (grant_count !== 16'd3) begin
            n_fail++;
            $display("FAIL st_grant_count: got %0d, want 3", grant_count);
        end
        n_vec++;
        if (stall_count !== 16'd4) begin
            n_fail++;
            $display("FAIL st_stall_count: got %0d, want 4", stall_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
